// File: rtl/mux8_rr_sched.sv
// Round-robin scheduler driving the select of a shared 8:1, 4-bit mux.
// Grants one requester at a time for at most BURST cycles, rotating priority after each release.
module mux8_rr_sched #(
  parameter int BURST = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] req,
  output logic [2:0] ctrl,
  output logic [7:0] gnt,
  output logic       valid,
  output logic       done
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(BURST - 1);

  state_t     state_q;
  logic [2:0] ctrl_q;
  logic [2:0] ptr_q;
  logic [7:0] gnt_q;
  logic       valid_q;
  logic       done_q;
  logic [3:0] cnt_q;

  logic       release_s;
  logic       arb_s;
  logic [2:0] ptr_d;
  logic [2:0] win_s;

  // First requester at or after p, wrapping modulo 8; the smallest offset is applied last so it wins.
  function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
    logic [2:0] idx;
    rr_pick = p;
    for (int k = 7; k >= 0; k--) begin
      idx = p + 3'(k);
      if (r[idx]) begin
        rr_pick = idx;
      end else begin
        rr_pick = rr_pick;
      end
    end
  endfunction

  // Release and arbitration decisions for the coming edge.
  always_comb begin
    release_s = 1'b0;
    ptr_d     = ptr_q;
    if (state_q == GRANT) begin
      release_s = !req[ctrl_q] || (cnt_q == CNT_LAST);
    end else begin
      release_s = 1'b0;
    end
    if (release_s) begin
      ptr_d = ctrl_q + 3'd1;
    end else begin
      ptr_d = ptr_q;
    end
    win_s = rr_pick(req, ptr_d);
    arb_s = en && (|req) && ((state_q == IDLE) || release_s);
  end

  // Scheduler state machine with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ctrl_q  <= 3'd0;
      ptr_q   <= 3'd0;
      gnt_q   <= 8'd0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= 4'd0;
    end else begin
      done_q <= release_s;
      ptr_q  <= ptr_d;
      if (arb_s) begin
        state_q <= GRANT;
        ctrl_q  <= win_s;
        gnt_q   <= 8'd1 << win_s;
        valid_q <= 1'b1;
        cnt_q   <= 4'd0;
      end else if ((state_q == GRANT) && !release_s) begin
        if (cnt_q != CNT_LAST) begin
          cnt_q <= cnt_q + 4'd1;
        end else begin
          cnt_q <= cnt_q;
        end
      end else begin
        // Idle or released with nobody to take over: ctrl keeps the last grantee.
        state_q <= IDLE;
        gnt_q   <= 8'd0;
        valid_q <= 1'b0;
        cnt_q   <= 4'd0;
      end
    end
  end

  assign ctrl  = ctrl_q;
  assign gnt   = gnt_q;
  assign valid = valid_q;
  assign done  = done_q;

endmodule

// File: tb/tb_mux8_rr_sched.sv
// Scoreboard bench for mux8_rr_sched: two instances (BURST=4 and BURST=1) checked
// cycle by cycle against a queue-fed reference model of the round-robin rules.
module tb_mux8_rr_sched;

  typedef struct {
    logic [2:0] ctrl;
    logic [7:0] gnt;
    logic       valid;
    logic       done;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [7:0] req = 8'd0;

  logic [2:0] d_ctrl  [2];
  logic [7:0] d_gnt   [2];
  logic       d_valid [2];
  logic       d_done  [2];

  int checks = 0;
  int failures = 0;

  exp_t q0[$];
  exp_t q1[$];

  // Reference model state per instance: current grantee (-1 when idle), cycles used, pointer.
  int m_cur  [2];
  int m_used [2];
  int m_ptr  [2];
  int m_ctrl [2];
  bit m_done [2];
  int bursts [2] = '{4, 1};

  always #5 clk = ~clk;

  mux8_rr_sched #(.BURST(4)) u_b4 (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .ctrl(d_ctrl[0]), .gnt(d_gnt[0]), .valid(d_valid[0]), .done(d_done[0])
  );

  mux8_rr_sched #(.BURST(1)) u_b1 (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .ctrl(d_ctrl[1]), .gnt(d_gnt[1]), .valid(d_valid[1]), .done(d_done[1])
  );

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cur[i]  = -1;
      m_used[i] = 0;
      m_ptr[i]  = 0;
      m_ctrl[i] = 0;
      m_done[i] = 1'b0;
    end
  endtask

  task automatic model_step(input int i, input logic e, input logic [7:0] r);
    bit rel;
    bit found;
    int idx;
    rel = 1'b0;
    if (m_cur[i] >= 0) begin
      if (!r[m_cur[i]] || m_used[i] == bursts[i]) begin
        rel = 1'b1;
        m_ptr[i] = (m_cur[i] + 1) % 8;
        m_cur[i] = -1;
      end else begin
        m_used[i]++;
      end
    end
    m_done[i] = rel;
    if (m_cur[i] < 0 && e && r != 8'd0) begin
      found = 1'b0;
      for (int k = 0; k < 8; k++) begin
        idx = (m_ptr[i] + k) % 8;
        if (!found && r[idx]) begin
          found = 1'b1;
          m_cur[i] = idx;
          m_used[i] = 1;
          m_ctrl[i] = idx;
        end
      end
    end
  endtask

  function automatic exp_t model_out(input int i);
    exp_t e;
    e.ctrl  = 3'(m_ctrl[i]);
    e.gnt   = (m_cur[i] >= 0) ? (8'd1 << m_cur[i]) : 8'd0;
    e.valid = (m_cur[i] >= 0);
    e.done  = m_done[i];
    return e;
  endfunction

  task automatic drive(input logic e, input logic [7:0] r);
    en  = e;
    req = r;
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_step(i, e, r);
    q0.push_back(model_out(0));
    q1.push_back(model_out(1));
    #1;
  endtask

  task automatic compare(input int i, input exp_t e);
    checks++;
    if (d_ctrl[i] !== e.ctrl || d_gnt[i] !== e.gnt || d_valid[i] !== e.valid || d_done[i] !== e.done) begin
      failures++;
      $display("FAIL out_b%0d t=%0t got ctrl=%0d gnt=%h valid=%b done=%b expected ctrl=%0d gnt=%h valid=%b done=%b",
               bursts[i], $time, d_ctrl[i], d_gnt[i], d_valid[i], d_done[i], e.ctrl, e.gnt, e.valid, e.done);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (d_ctrl[i] !== 3'd0 || d_gnt[i] !== 8'd0 || d_valid[i] !== 1'b0 || d_done[i] !== 1'b0) begin
        failures++;
        $display("FAIL %s_b%0d got ctrl=%0d gnt=%h valid=%b done=%b expected all zero",
                 tag, bursts[i], d_ctrl[i], d_gnt[i], d_valid[i], d_done[i]);
      end
    end
  endtask

  // Monitor: compare each presented output cycle against the oldest expectation.
  always @(negedge clk) begin
    if (q0.size() > 0) compare(0, q0.pop_front());
    if (q1.size() > 0) compare(1, q1.pop_front());
  end

  initial begin
    logic [7:0] r;
    logic       e;
    model_reset();
    #3;
    check_reset_outputs("reset_init");
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    drive(1'b0, 8'h00);
    drive(1'b0, 8'hFF);
    // Single requester: bursts and back-to-back re-grant.
    repeat (12) drive(1'b1, 8'h08);
    repeat (3) drive(1'b1, 8'h00);
    // Full rotation with no idle gaps.
    repeat (36) drive(1'b1, 8'hFF);
    repeat (3) drive(1'b1, 8'h00);
    // Wrap priority between indices 7 and 0.
    repeat (20) drive(1'b1, 8'h81);
    repeat (3) drive(1'b1, 8'h00);
    // Enable gating mid-grant.
    repeat (2) drive(1'b1, 8'h06);
    repeat (6) drive(1'b0, 8'h06);
    repeat (6) drive(1'b1, 8'h06);

    // Asynchronous reset mid-grant.
    repeat (2) drive(1'b1, 8'hFF);
    #1;
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    model_reset();
    #1;
    check_reset_outputs("reset_mid");
    en  = 1'b1;
    req = 8'hFF;
    @(posedge clk);
    #1;
    check_reset_outputs("reset_held");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    repeat (3) drive(1'b1, 8'h00);

    // Early release: grant 0, req[0] low during the third grant cycle.
    repeat (3) drive(1'b1, 8'h21);
    repeat (3) drive(1'b1, 8'h20);
    repeat (3) drive(1'b1, 8'hFF);

    // Randomized traffic.
    r = 8'h00;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) r = 8'($urandom) & 8'($urandom);
      e = ($urandom_range(0, 7) != 0);
      drive(e, r);
    end

    @(negedge clk);
    #1;
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      failures++;
      $display("FAIL drain got pending=%0d expected pending=0", q0.size() + q1.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
